// File: rtl/allpass_coef_ctrl.sv
// -----------------------------------------------------------------------------
// allpass_coef_ctrl
//
// Coefficient controller for the allpass filter section. The host loads a
// shadow bank one word at a time. A commit copies the shadow bank into the
// active bank (the packed c bus) in a single edge. After the copy the filter
// is held in reset for FLUSH cycles and its output is masked for a further
// N-1 cycles while the delay line refills. The same flush/settle sequence runs
// after reset release.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   wr_en       in   write strobe for one shadow coefficient
//   wr_addr     in   coefficient index, valid range 0..N-2
//   wr_data     in   signed coefficient value
//   wr_ready    out  writes are accepted this cycle (IDLE)
//   wr_err      out  registered pulse, one cycle after wr_en with wr_addr >= N-1
//   commit      in   request to swap shadow bank into active bank
//   c           out  active coefficients, word g at [WIDTH*(g+1)-1:WIDTH*g]
//   filt_rst    out  active-high synchronous reset to the filter
//   dout_valid  out  filter output valid under the current coefficients
//   busy        out  swap/flush/settle sequence in progress
//   dbg_state   out  current FSM state (0=IDLE, 1=FLUSH, 2=SETTLE)
//
// Handshake: a write is taken on any rising edge where wr_en=1 and
// wr_ready=1; wr_en while wr_ready=0 is dropped (only the address range
// check still runs). commit is a single-cycle request, honoured only in IDLE
// and only if there is something new to commit; otherwise it is dropped.
// -----------------------------------------------------------------------------
module allpass_coef_ctrl #(
    parameter int WIDTH = 16,
    parameter int N     = 5,
    parameter int FLUSH = 4,
    parameter int AW    = (N - 1 > 1) ? $clog2(N - 1) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    output logic                     wr_err,
    input  logic                     commit,
    output logic [WIDTH*(N-1)-1:0]   c,
    output logic                     filt_rst,
    output logic                     dout_valid,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    localparam int NC   = N - 1;
    localparam int CMAX = (FLUSH > NC) ? FLUSH : NC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int AW1  = AW + 1;

    localparam logic [CW-1:0]  CNT_FLUSH  = CW'(FLUSH - 1);
    localparam logic [CW-1:0]  CNT_SETTLE = CW'(N - 2);
    // One extra bit so that N-1 is representable even when it is 2**AW.
    localparam logic [AW1-1:0] NC_W       = AW1'(NC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLUSH  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q [NC];
    logic [WIDTH-1:0] shadow_d [NC];
    logic [WIDTH-1:0] active_q [NC];
    logic [WIDTH-1:0] active_d [NC];
    logic             dirty_q, dirty_d;
    logic             wr_err_q, wr_err_d;

    logic addr_ok;
    logic wr_hit;

    always_comb begin
        addr_ok  = ({1'b0, wr_addr} < NC_W);
        wr_hit   = (state_q == S_IDLE) && wr_en && addr_ok;
        wr_err_d = wr_en && !addr_ok;

        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;

        case (state_q)
            S_IDLE: begin
                if (wr_hit) begin
                    for (int g = 0; g < NC; g++) begin
                        if (wr_addr == AW'(g)) begin
                            shadow_d[g] = wr_data;
                        end
                    end
                    dirty_d = 1'b1;
                end
                // shadow_d already holds a same-cycle write, so the copy
                // picks it up.
                if (commit && (dirty_q || wr_hit)) begin
                    active_d = shadow_d;
                    dirty_d  = 1'b0;
                    state_d  = S_FLUSH;
                    cnt_d    = CNT_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_SETTLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_FLUSH;
                cnt_d   = CNT_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FLUSH;
            cnt_q    <= CNT_FLUSH;
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            dirty_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            dirty_q  <= dirty_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Status outputs decode from the state register only.
    always_comb begin
        c = '0;
        for (int g = 0; g < NC; g++) begin
            c[g*WIDTH +: WIDTH] = active_q[g];
        end
    end

    assign wr_ready   = (state_q == S_IDLE);
    assign dout_valid = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign filt_rst   = (state_q == S_FLUSH);
    assign wr_err     = wr_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_allpass_coef_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for allpass_coef_ctrl (N=5, WIDTH=16, FLUSH=4). The address bus is
// widened to 3 bits so that out-of-range indices (4..7) can be driven.
// The reference keeps the banks as plain arrays and the sequence as a single
// "cycles of busy remaining" number.
// -----------------------------------------------------------------------------
module tb_allpass_coef_ctrl;

    localparam int WIDTH    = 16;
    localparam int N        = 5;
    localparam int FLUSH    = 4;
    localparam int AW       = 3;
    localparam int NC       = N - 1;
    localparam int BUSY_LEN = FLUSH + N - 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   wr_en   = 1'b0;
    logic [AW-1:0]          wr_addr = '0;
    logic [WIDTH-1:0]       wr_data = '0;
    logic                   commit  = 1'b0;
    logic                   wr_ready, wr_err, filt_rst, dout_valid, busy;
    logic [WIDTH*NC-1:0]    c;
    logic [1:0]             dbg_state;

    allpass_coef_ctrl #(.WIDTH(WIDTH), .N(N), .FLUSH(FLUSH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .wr_err     (wr_err),
        .commit     (commit),
        .c          (c),
        .filt_rst   (filt_rst),
        .dout_valid (dout_valid),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] shadow_m [NC];
    logic [WIDTH-1:0] active_m [NC];
    bit               dirty_m;
    bit               err_m;
    int               rem;      // busy cycles still to come, 0 = idle

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        dirty_m = 1'b0;
        err_m   = 1'b0;
        rem     = BUSY_LEN;
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        err_m = wr_en && (int'(wr_addr) >= NC);
        if (rem == 0) begin
            if (wr_en && int'(wr_addr) < NC) begin
                shadow_m[int'(wr_addr)] = wr_data;
                dirty_m = 1'b1;
            end
            if (commit && dirty_m) begin
                active_m = shadow_m;
                dirty_m  = 1'b0;
                rem      = BUSY_LEN;
            end
        end else begin
            rem--;
        end
    endfunction

    function automatic logic [63:0] model_c();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[i*WIDTH +: WIDTH] = active_m[i];
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("c",          64'(c),          model_c());
        chk("filt_rst",   64'(filt_rst),   64'(rem > N - 1));
        chk("dout_valid", 64'(dout_valid), 64'(rem == 0));
        chk("busy",       64'(busy),       64'(rem != 0));
        chk("wr_ready",   64'(wr_ready),   64'(rem == 0));
        chk("wr_err",     64'(wr_err),     64'(err_m));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic en, input int addr, input logic [WIDTH-1:0] data,
                          input logic cm);
        wr_en   = en;
        wr_addr = AW'(addr);
        wr_data = data;
        commit  = cm;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            cycle();
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    // Counts busy cycles starting with the current one.
    task automatic measure_busy(output int n);
        int guard = 0;
        n = busy ? 1 : 0;
        while (busy && guard < 40) begin
            cycle();
            guard++;
            if (busy) n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int fr;

        model_reset();

        // Reset held, then release.
        repeat (3) cycle();
        rst_n = 1'b1;
        fr = filt_rst ? 1 : 0;
        n  = busy ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (filt_rst) fr++;
            if (busy) n++;
        end
        chk("rst_filt_cycles", 64'(fr), 64'(FLUSH));
        chk("rst_busy_cycles", 64'(n), 64'(BUSY_LEN));
        chk("rst_c_zero", 64'(c), 64'(0));

        // Full load.
        set_in(1, 0, 16'h1000, 0); cycle();
        set_in(1, 1, 16'h0800, 0); cycle();
        set_in(1, 2, 16'hF800, 0); cycle();
        set_in(1, 3, 16'h0400, 0); cycle();
        set_in(0, 0, 16'h0000, 1); cycle();
        set_in(0, 0, 16'h0000, 0);
        chk("full_load_c", 64'(c), 64'h0400_F800_0800_1000);
        measure_busy(n);
        chk("full_load_busy_len", 64'(n), 64'(BUSY_LEN));

        // Same-cycle write and commit.
        set_in(1, 2, 16'h1234, 1); cycle();
        set_in(0, 0, 16'h0000, 0);
        chk("same_cycle_word2", 64'(c[47:32]), 64'h1234);
        wait_idle();

        // Clean commit: nothing new, no flush.
        set_in(0, 0, 16'h0000, 1); cycle();
        set_in(0, 0, 16'h0000, 0);
        chk("clean_commit_filt", 64'(filt_rst), 64'(0));
        chk("clean_commit_c", 64'(c), 64'h0400_1234_0800_1000);
        repeat (2) cycle();

        // Blocked activity during FLUSH.
        set_in(1, 3, 16'h0111, 1); cycle();
        chk("blocked_wr_ready", 64'(wr_ready), 64'(0));
        set_in(1, 0, 16'h7FFF, 1); cycle();
        set_in(0, 0, 16'h0000, 0);
        wait_idle();
        set_in(0, 0, 16'h0000, 1); cycle();
        set_in(0, 0, 16'h0000, 0);
        chk("blocked_commit_dropped", 64'(filt_rst), 64'(0));
        set_in(1, 1, 16'h0222, 1); cycle();
        set_in(0, 0, 16'h0000, 0);
        wait_idle();
        chk("shadow0_kept", 64'(c[15:0]), 64'h1000);

        // Out-of-range write.
        set_in(1, 4, 16'hDEAD, 0); cycle();
        set_in(0, 0, 16'h0000, 0);
        chk("wr_err_pulse", 64'(wr_err), 64'(1));
        cycle();
        chk("wr_err_single", 64'(wr_err), 64'(0));
        set_in(0, 0, 16'h0000, 1); cycle();
        set_in(0, 0, 16'h0000, 0);
        chk("err_no_dirty", 64'(filt_rst), 64'(0));

        // Reset asserted in SETTLE.
        set_in(1, 0, 16'h0ABC, 1); cycle();
        set_in(0, 0, 16'h0000, 0);
        repeat (5) cycle();
        chk("in_settle", 64'({filt_rst, busy}), 64'(2'b01));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_c", 64'(c), 64'(0));
        chk("async_rst_filt", 64'(filt_rst), 64'(1));
        chk("async_rst_ready", 64'(wr_ready), 64'(0));
        repeat (2) cycle();
        rst_n = 1'b1;
        measure_busy(n);
        chk("rerun_busy_len", 64'(n), 64'(BUSY_LEN));
        chk("rerun_c_zero", 64'(c), 64'(0));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   WIDTH'($urandom), 1'($urandom_range(0, 3) == 0));
            cycle();
        end
        set_in(0, 0, 16'h0000, 0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
